// File: rtl/mem_access_unit.sv
// Load/store unit: word-aligned data memory access, sub-word stores as read-modify-write.
// Define LSU_MISALIGN_SPLIT_EN to split word-spanning accesses into two word accesses.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] dm_address,
  output logic [31:0]           dm_write_data,
  output logic                  dm_mem_write,
  output logic                  dm_mem_read,
  input  logic [31:0]           dm_read_data
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, lo_q, hi_q;
  logic [2:0]            funct3_q;
  logic                  write_q;

  logic                  req_ready_q, rsp_valid_q, rsp_err_q, dm_mem_write_q, dm_mem_read_q;
  logic [31:0]           rsp_rdata_q, dm_write_data_q;
  logic [ADDR_WIDTH-1:0] dm_address_q;

  // In IDLE the request itself is decoded so the first access can be registered at acceptance.
  logic [ADDR_WIDTH-1:0] cur_addr, word0, word1, dm_address_d;
  logic [2:0]            cur_f3;
  logic                  cur_wr;
  logic [31:0]           cur_wdata, lo_nx, hi_nx, ld_word, ld_ext, rsp_rdata_d, dm_write_data_d;
  logic [1:0]            off;
  logic [3:0]            size_m;
  logic [2:0]            nbytes;
  logic                  illegal, span, accept_err;
  logic [63:0]           cat, wide_data, merged;
  logic [7:0]            wide_mask;

  always_comb begin
    cur_addr  = (state_q == IDLE) ? req_addr   : addr_q;
    cur_f3    = (state_q == IDLE) ? req_funct3 : funct3_q;
    cur_wr    = (state_q == IDLE) ? req_write  : write_q;
    cur_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;
    off       = cur_addr[1:0];

    case (cur_f3[1:0])
      2'b00:   begin size_m = 4'b0001; nbytes = 3'd1; end
      2'b01:   begin size_m = 4'b0011; nbytes = 3'd2; end
      2'b10:   begin size_m = 4'b1111; nbytes = 3'd4; end
      default: begin size_m = 4'b0000; nbytes = 3'd0; end
    endcase
    illegal    = (cur_f3 == 3'b011) || (cur_f3 == 3'b110) || (cur_f3 == 3'b111) ||
                 (cur_wr && cur_f3[2]);
    span       = ({2'b00, off} + {1'b0, nbytes}) > 4'd4;
    accept_err = illegal || (span && !SPLIT_EN);

    word0 = {cur_addr[ADDR_WIDTH-1:2], 2'b00};
    word1 = word0 + ADDR_WIDTH'(4);

    lo_nx = (state_q == RD0) ? dm_read_data : lo_q;
    hi_nx = (state_q == RD1) ? dm_read_data : hi_q;
    cat   = {hi_nx, lo_nx};

    ld_word = 32'(cat >> {off, 3'b000});
    case (cur_f3)
      3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b010:  ld_ext = ld_word;
      3'b100:  ld_ext = {24'd0, ld_word[7:0]};
      3'b101:  ld_ext = {16'd0, ld_word[15:0]};
      default: ld_ext = 32'd0;
    endcase

    wide_data = {32'd0, cur_wdata} << {off, 3'b000};
    wide_mask = {4'b0000, size_m} << off;
    for (int i = 0; i < 8; i++)
      merged[i*8 +: 8] = wide_mask[i] ? wide_data[i*8 +: 8] : cat[i*8 +: 8];

    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (accept_err)                                   state_d = DONE;
        else if (cur_wr && cur_f3 == 3'b010 && off == 2'b00) state_d = WR0;
        else                                              state_d = RD0;
      end
      RD0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        if (span)        state_d = RD1;
        else
`endif
        if (cur_wr)      state_d = WR0;
        else             state_d = DONE;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      RD1:               state_d = cur_wr ? WR0 : DONE;
      WR0:               state_d = span ? WR1 : DONE;
      WR1:               state_d = DONE;
`else
      WR0:               state_d = DONE;
`endif
      DONE:              state_d = IDLE;
      default:           state_d = IDLE;
    endcase

    case (state_d)
      RD0, WR0: dm_address_d = word0;
      RD1, WR1: dm_address_d = word1;
      default:  dm_address_d = '0;
    endcase
    case (state_d)
      WR0:     dm_write_data_d = merged[31:0];
      WR1:     dm_write_data_d = merged[63:32];
      default: dm_write_data_d = 32'd0;
    endcase
    rsp_rdata_d = (state_d == DONE && state_q != IDLE && !cur_wr) ? ld_ext : 32'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      wdata_q         <= 32'd0;
      funct3_q        <= 3'd0;
      write_q         <= 1'b0;
      lo_q            <= 32'd0;
      hi_q            <= 32'd0;
      req_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_rdata_q     <= 32'd0;
      dm_address_q    <= '0;
      dm_write_data_q <= 32'd0;
      dm_mem_write_q  <= 1'b0;
      dm_mem_read_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
        write_q  <= req_write;
      end
      state_q         <= state_d;
      lo_q            <= lo_nx;
      hi_q            <= hi_nx;
      req_ready_q     <= (state_d == IDLE);
      rsp_valid_q     <= (state_d == DONE);
      // Only the error path jumps straight from IDLE to DONE.
      rsp_err_q       <= (state_d == DONE) && (state_q == IDLE);
      rsp_rdata_q     <= rsp_rdata_d;
      dm_address_q    <= dm_address_d;
      dm_write_data_q <= dm_write_data_d;
      dm_mem_read_q   <= (state_d == RD0) || (state_d == RD1);
      dm_mem_write_q  <= (state_d == WR0) || (state_d == WR1);
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign dm_address    = dm_address_q;
  assign dm_write_data = dm_write_data_q;
  assign dm_mem_write  = dm_mem_write_q;
  assign dm_mem_read   = dm_mem_read_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-addressed memory model and a response scoreboard.
// Expectations follow LSU_MISALIGN_SPLIT_EN when it is defined for the build.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, dm_mem_write, dm_mem_read;
  logic [31:0] rsp_rdata, dm_address, dm_write_data, dm_read_data;

  logic [31:0] mem [64];
  int          wr_cnt = 0, rd_cnt = 0;
  logic [31:0] last_wr_addr;
  int          checks = 0, errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dm_address(dm_address), .dm_write_data(dm_write_data),
    .dm_mem_write(dm_mem_write), .dm_mem_read(dm_mem_read),
    .dm_read_data(dm_read_data)
  );

  assign dm_read_data = mem[dm_address[7:2]];

  always @(posedge clk) begin
    if (rst_n && dm_mem_write) begin
      mem[dm_address[7:2]] = dm_write_data;
      last_wr_addr = dm_address;
      wr_cnt++;
    end
    if (rst_n && dm_mem_read) rd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int el);
    exp_t e;
    int   lat;
    bit   got;
    sb.push_back('{rdata: er, err: ee, lat: el});
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) got = 1;
      else lat++;
    end
    if (!got) begin
      chk({tag, " rsp_timeout"}, 32'(got), 32'd1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({tag, " rdata"}, rsp_rdata, e.rdata);
      chk({tag, " err"}, 32'(rsp_err), 32'(e.err));
      chk({tag, " latency"}, lat, e.lat);
      @(negedge clk);
      chk({tag, " single_pulse"}, 32'(rsp_valid), 32'd0);
      chk({tag, " idle_ready"}, 32'(req_ready), 32'd1);
    end
  endtask

  int w0, r0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst dm_ctrl", {30'd0, dm_mem_write, dm_mem_read}, 32'd0);
    chk("rst dm_address", dm_address, 32'd0);
    chk("rst dm_write_data", dm_write_data, 32'd0);
    rst_n = 1'b1;

    // Aligned and sub-word loads from word 0x10
    mem[4] = 32'h8899AABB;
    r0 = rd_cnt;
    do_req("LB13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2);
    chk("LB13 reads", rd_cnt - r0, 32'd1);
    do_req("LBU13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000088, 1'b0, 2);
    do_req("LHU12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h00008899, 1'b0, 2);
    do_req("LH10",  1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 2);
    do_req("LW10",  1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2);

    // Sub-word store read-modify-write
    w0 = wr_cnt;
    do_req("SB11", 1'b1, 3'b000, 32'h11, 32'h12345655, 32'h0, 1'b0, 3);
    chk("SB11 mem", mem[4], 32'h889955BB);
    chk("SB11 writes", wr_cnt - w0, 32'd1);
    chk("SB11 addr", last_wr_addr, 32'h10);

    // Aligned SW skips the read
    mem[5] = 32'h01020304;
    w0 = wr_cnt; r0 = rd_cnt;
    do_req("SW14", 1'b1, 3'b010, 32'h14, 32'hCAFEF00D, 32'h0, 1'b0, 2);
    chk("SW14 mem", mem[5], 32'hCAFEF00D);
    chk("SW14 reads", rd_cnt - r0, 32'd0);
    chk("SW14 writes", wr_cnt - w0, 32'd1);
    do_req("SH16", 1'b1, 3'b001, 32'h16, 32'h1234BEEF, 32'h0, 1'b0, 3);
    chk("SH16 mem", mem[5], 32'hBEEFF00D);

    // Word-spanning accesses
    mem[3] = 32'h44332211; mem[4] = 32'h88776655;
    r0 = rd_cnt;
    if (SPLIT) begin
      do_req("LW0E", 1'b0, 3'b010, 32'h0E, 32'h0, 32'h66554433, 1'b0, 3);
      chk("LW0E reads", rd_cnt - r0, 32'd2);
      do_req("LH0F", 1'b0, 3'b001, 32'h0F, 32'h0, 32'h00005544, 1'b0, 3);
    end else begin
      do_req("LW0E", 1'b0, 3'b010, 32'h0E, 32'h0, 32'h0, 1'b1, 1);
      chk("LW0E reads", rd_cnt - r0, 32'd0);
      do_req("LH0F", 1'b0, 3'b001, 32'h0F, 32'h0, 32'h0, 1'b1, 1);
    end
    w0 = wr_cnt;
    if (SPLIT) begin
      do_req("SW0E", 1'b1, 3'b010, 32'h0E, 32'hDDCCBBAA, 32'h0, 1'b0, 5);
      chk("SW0E lo", mem[3], 32'hBBAA2211);
      chk("SW0E hi", mem[4], 32'h8877DDCC);
      chk("SW0E writes", wr_cnt - w0, 32'd2);
    end else begin
      do_req("SW0E", 1'b1, 3'b010, 32'h0E, 32'hDDCCBBAA, 32'h0, 1'b1, 1);
      chk("SW0E lo", mem[3], 32'h44332211);
      chk("SW0E hi", mem[4], 32'h88776655);
      chk("SW0E writes", wr_cnt - w0, 32'd0);
    end

    // Illegal funct3 encodings
    w0 = wr_cnt; r0 = rd_cnt;
    do_req("L011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    do_req("S100", 1'b1, 3'b100, 32'h10, 32'h55, 32'h0, 1'b1, 1);
    chk("illegal pulses", (wr_cnt - w0) + (rd_cnt - r0), 32'd0);

    // Reset during WR0 of an SB
    mem[8] = 32'h11111111;
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'hAB;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid in_wr0", 32'(dm_mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid write_drop", 32'(dm_mem_write), 32'd0);
    chk("rstmid rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstmid no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("rstmid ready", 32'(req_ready), 32'd1);
    chk("rstmid mem", mem[8], 32'h11111111);
    chk("rstmid writes", wr_cnt - w0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
